// File: rtl/if_id_dual_if.sv
// Bundle of fetch-side inputs and IF/ID-side outputs for the dual-lane IF/ID register.
interface if_id_dual_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      if_instruction_r_i;
  logic [31:0]      if_instruction_i_i;
  logic [31:0]      if_pc_i;
  logic             if_valid_i;
  logic             hazard_i;
  logic             flush_i;
  logic [31:0]      IF_ID_instruction_r;
  logic [31:0]      IF_ID_instruction_i;
  logic [31:0]      IF_ID_pc;
  logic             IF_ID_valid;
  logic             pc_write_o;
  logic             id_ex_bubble_o;
  logic [CNT_W-1:0] stall_count_o;
  logic [CNT_W-1:0] flush_count_o;

  modport slave (
    input  if_instruction_r_i, if_instruction_i_i, if_pc_i, if_valid_i, hazard_i, flush_i,
    output IF_ID_instruction_r, IF_ID_instruction_i, IF_ID_pc, IF_ID_valid,
           pc_write_o, id_ex_bubble_o, stall_count_o, flush_count_o
  );

  modport master (
    output if_instruction_r_i, if_instruction_i_i, if_pc_i, if_valid_i, hazard_i, flush_i,
    input  IF_ID_instruction_r, IF_ID_instruction_i, IF_ID_pc, IF_ID_valid,
           pc_write_o, id_ex_bubble_o, stall_count_o, flush_count_o
  );
endinterface

// File: rtl/if_id_dual_register.sv
// Dual-lane IF/ID pipeline register with load-use stall, multi-cycle flush squash
// and saturating stall/flush statistics counters.
//
// state  | meaning
// RUN    | normal capture; hazard stalls, flush squashes the current edge
// SQUASH | extra post-flush cycles: lanes forced to NOP, fetch discarded
module if_id_dual_register #(
  parameter logic [31:0] NOP_WORD     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input logic         clk,
  input logic         rst_n,
  if_id_dual_if.slave bus
);

  typedef enum logic {RUN, SQUASH} state_t;

  localparam logic [1:0] SQ_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       sq_cnt_q, sq_cnt_d;
  logic [31:0]      instr_r_q, instr_r_d;
  logic [31:0]      instr_i_q, instr_i_d;
  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_req;
  logic             bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      sq_cnt_q    <= '0;
      instr_r_q   <= NOP_WORD;
      instr_i_q   <= NOP_WORD;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sq_cnt_q    <= sq_cnt_d;
      instr_r_q   <= instr_r_d;
      instr_i_q   <= instr_i_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // rst_n gates the stall so the PC keeps its write enable while held in reset
  assign stall_req = rst_n && (state_q == RUN) && bus.hazard_i && !bus.flush_i;
  assign bubble    = stall_req || (rst_n && (state_q == SQUASH));

  always_comb begin
    state_d     = state_q;
    sq_cnt_d    = sq_cnt_q;
    instr_r_d   = instr_r_q;
    instr_i_d   = instr_i_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      RUN: begin
        if (bus.flush_i) begin
          instr_r_d = NOP_WORD;
          instr_i_d = NOP_WORD;
          valid_d   = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state_d  = SQUASH;
            sq_cnt_d = SQ_RELOAD;
          end
          if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (bus.hazard_i) begin
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
          instr_r_d = bus.if_valid_i ? bus.if_instruction_r_i : NOP_WORD;
          instr_i_d = bus.if_valid_i ? bus.if_instruction_i_i : NOP_WORD;
          pc_d      = bus.if_pc_i;
          valid_d   = bus.if_valid_i;
        end
      end
      SQUASH: begin
        instr_r_d = NOP_WORD;
        instr_i_d = NOP_WORD;
        valid_d   = 1'b0;
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        if (bus.flush_i) begin
          if (FLUSH_CYCLES > 1) begin
            sq_cnt_d = SQ_RELOAD;
          end else begin
            state_d  = RUN;
            sq_cnt_d = '0;
          end
        end else begin
          sq_cnt_d = sq_cnt_q - 2'd1;
          if (sq_cnt_q <= 2'd1) state_d = RUN;
        end
      end
      default: begin
        state_d  = RUN;
        sq_cnt_d = '0;
      end
    endcase
  end

  assign bus.IF_ID_instruction_r = instr_r_q;
  assign bus.IF_ID_instruction_i = instr_i_q;
  assign bus.IF_ID_pc            = pc_q;
  assign bus.IF_ID_valid         = valid_q;
  assign bus.pc_write_o          = !stall_req;
  assign bus.id_ex_bubble_o      = bubble;
  assign bus.stall_count_o       = stall_cnt_q;
  assign bus.flush_count_o       = flush_cnt_q;

endmodule

// File: tb/tb_if_id_dual_register.sv
// Randomized bench: two DUTs (3-cycle squash / 4-bit counters, 1-cycle flush / 16-bit
// counters) driven in lockstep and compared against a cycle-level behavioural model.
module tb_if_id_dual_register;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  if_id_dual_if #(.CNT_W(4))  bus_a ();
  if_id_dual_if #(.CNT_W(16)) bus_b ();

  if_id_dual_register #(.NOP_WORD(NOP), .FLUSH_CYCLES(3), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  if_id_dual_register #(.NOP_WORD(NOP), .FLUSH_CYCLES(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: per instance, contents of IF/ID plus how many further edges will be squashed
  typedef struct {
    logic [31:0] r, i, pc;
    bit          v;
    int          squash_left;
    int          stall, flush;
  } mdl_t;

  mdl_t m[2];
  int   fc[2]   = '{3, 1};
  int   cmax[2] = '{15, 65535};

  logic [31:0] in_r, in_i, in_pc;
  logic        in_v, in_hz, in_fl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].r = NOP; m[k].i = NOP; m[k].pc = '0; m[k].v = 0;
      m[k].squash_left = 0; m[k].stall = 0; m[k].flush = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m[k].r = NOP; m[k].i = NOP; m[k].pc = '0; m[k].v = 0;
        m[k].squash_left = 0; m[k].stall = 0; m[k].flush = 0;
      end else if (m[k].squash_left > 0 || in_fl) begin
        m[k].r = NOP; m[k].i = NOP; m[k].v = 0;
        if (m[k].flush < cmax[k]) m[k].flush++;
        m[k].squash_left = in_fl ? fc[k] - 1 : m[k].squash_left - 1;
      end else if (in_hz) begin
        if (m[k].stall < cmax[k]) m[k].stall++;
      end else begin
        m[k].r  = in_v ? in_r : NOP;
        m[k].i  = in_v ? in_i : NOP;
        m[k].pc = in_pc;
        m[k].v  = in_v;
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [31:0] o_r, o_i, o_pc, o_st, o_fl;
    logic        o_v, o_pw, o_bb;
    bit          stall_now, bub;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        o_r = bus_a.IF_ID_instruction_r; o_i = bus_a.IF_ID_instruction_i; o_pc = bus_a.IF_ID_pc;
        o_v = bus_a.IF_ID_valid; o_pw = bus_a.pc_write_o; o_bb = bus_a.id_ex_bubble_o;
        o_st = 32'(bus_a.stall_count_o); o_fl = 32'(bus_a.flush_count_o);
      end else begin
        o_r = bus_b.IF_ID_instruction_r; o_i = bus_b.IF_ID_instruction_i; o_pc = bus_b.IF_ID_pc;
        o_v = bus_b.IF_ID_valid; o_pw = bus_b.pc_write_o; o_bb = bus_b.id_ex_bubble_o;
        o_st = 32'(bus_b.stall_count_o); o_fl = 32'(bus_b.flush_count_o);
      end
      stall_now = rst_n && m[k].squash_left == 0 && in_hz && !in_fl;
      bub       = stall_now || (rst_n && m[k].squash_left > 0);
      check($sformatf("%s[%0d].instr_r", ph, k), o_r, m[k].r);
      check($sformatf("%s[%0d].instr_i", ph, k), o_i, m[k].i);
      check($sformatf("%s[%0d].pc", ph, k), o_pc, m[k].pc);
      check($sformatf("%s[%0d].valid", ph, k), 32'(o_v), 32'(m[k].v));
      check($sformatf("%s[%0d].pc_write", ph, k), 32'(o_pw), 32'(!stall_now));
      check($sformatf("%s[%0d].bubble", ph, k), 32'(o_bb), 32'(bub));
      check($sformatf("%s[%0d].stall_cnt", ph, k), o_st, 32'(m[k].stall));
      check($sformatf("%s[%0d].flush_cnt", ph, k), o_fl, 32'(m[k].flush));
    end
  endtask

  task automatic drive(input logic [31:0] r, input logic [31:0] i, input logic [31:0] pc,
                       input logic v, input logic hz, input logic fl);
    in_r = r; in_i = i; in_pc = pc; in_v = v; in_hz = hz; in_fl = fl;
    bus_a.if_instruction_r_i = r; bus_a.if_instruction_i_i = i; bus_a.if_pc_i = pc;
    bus_a.if_valid_i = v; bus_a.hazard_i = hz; bus_a.flush_i = fl;
    bus_b.if_instruction_r_i = r; bus_b.if_instruction_i_i = i; bus_b.if_pc_i = pc;
    bus_b.if_valid_i = v; bus_b.hazard_i = hz; bus_b.flush_i = fl;
  endtask

  // apply inputs, check everything before the edge, then advance the model with the edge
  task automatic step(input string ph, input logic [31:0] pc, input logic v,
                      input logic hz, input logic fl);
    drive($urandom, $urandom, pc, v, hz, fl);
    #1;
    check_all(ph);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    step("reset", 32'h0, 1'b1, 1'b1, 1'b0);
    step("reset", 32'h0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;

    step("stream", 32'h00, 1'b1, 1'b0, 1'b0);
    step("stream", 32'h08, 1'b1, 1'b0, 1'b0);
    step("stall",  32'h10, 1'b1, 1'b1, 1'b0);
    step("stall",  32'h10, 1'b1, 1'b0, 1'b0);
    step("stream", 32'h18, 1'b0, 1'b0, 1'b0);
    step("hz_fl",  32'h20, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) step("squash", 32'h28 + 32'(8 * c), 1'b1, c == 0, 1'b0);
    step("resume", 32'h48, 1'b1, 1'b0, 1'b0);

    for (int c = 0; c < 20; c++) step("satur", 32'h50, 1'b1, 1'b1, 1'b0);
    step("satur_end", 32'h50, 1'b1, 1'b0, 1'b0);

    // reset asserted asynchronously in the middle of a squash, with hazard held
    step("pre_rst", 32'h60, 1'b1, 1'b0, 1'b1);
    drive($urandom, $urandom, 32'h68, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    step("in_rst", 32'h68, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    step("post_rst", 32'h70, 1'b1, 1'b0, 1'b0);
    step("post_rst", 32'h78, 1'b1, 1'b0, 1'b0);

    for (int c = 0; c < 400; c++) begin
      step("rand", $urandom & 32'hFFFF_FFF8, ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end
    step("final", 32'h0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_dual_register.md
Name: if_id_dual_register

Overview:
- Dual-lane IF/ID pipeline register for the double-issue MIPS core. Holds the R-lane and I-lane instruction pair plus its PC between fetch and decode.
- Consumes the load-use `hazard` flag from the hazard detection unit and branch/jump flush requests.
- Produces the IF_ID instruction pair that the hazard unit compares against, the PC write-enable, and the ID/EX bubble control.
- Counts stall and flush cycles for on-board debug.

Parameters:
- NOP_WORD, 32'h0000_0000, instruction word loaded into both lanes on flush or reset
- FLUSH_CYCLES, 1, number of consecutive cycles squashed after a flush request (1..3)
- CNT_W, 16, width of the stall and flush statistics counters

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_instruction_r_i  in  32  fetched R-lane instruction
- if_instruction_i_i  in  32  fetched I-lane instruction
- if_pc_i  in  32  PC of the fetched pair
- if_valid_i  in  1  fetched pair is valid this cycle
- hazard_i  in  1  load-use hazard from the hazard detection unit
- flush_i  in  1  branch/jump taken; squash the younger pair
- IF_ID_instruction_r  out  32  registered R-lane instruction
- IF_ID_instruction_i  out  32  registered I-lane instruction
- IF_ID_pc  out  32  registered pair PC
- IF_ID_valid  out  1  registered pair is valid
- pc_write_o  out  1  PC register write enable
- id_ex_bubble_o  out  1  force ID/EX control fields to zero this cycle
- stall_count_o  out  CNT_W  saturating count of hazard stall cycles
- flush_count_o  out  CNT_W  saturating count of squashed cycles

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Both lanes = NOP_WORD; IF_ID_pc = 0; IF_ID_valid = 0.
  - State = RUN; squash counter = 0; stall_count_o = 0; flush_count_o = 0.
- Combinational outputs:
  - pc_write_o = !(state==RUN && hazard_i && !flush_i).
  - id_ex_bubble_o = 1 when (state==RUN && hazard_i && !flush_i), or when state==SQUASH; otherwise 0.
  - Both outputs are 1 and 0 respectively during reset.
- States: RUN, SQUASH.
- RUN, per rising edge, in priority order:
  - flush_i=1: load NOP_WORD into both lanes; valid=0; pc unchanged.
    - If FLUSH_CYCLES>1: move to SQUASH with squash counter = FLUSH_CYCLES-1.
    - flush_count_o += 1.
    - flush_i overrides hazard_i in the same cycle.
  - hazard_i=1: hold all IF_ID registers unchanged; stall_count_o += 1.
  - Otherwise: load if_instruction_r_i, if_instruction_i_i, if_pc_i and valid=if_valid_i.
    - When if_valid_i=0, both lanes load NOP_WORD.
- SQUASH, per rising edge:
  - Lanes = NOP_WORD; valid = 0; fetched input discarded.
  - Counter decrements; return to RUN when it reaches 0.
  - hazard_i is ignored and not counted.
  - flush_i reloads counter = FLUSH_CYCLES-1 and stays in SQUASH (or goes to RUN if FLUSH_CYCLES=1).
  - flush_count_o += 1 each SQUASH cycle.
- Hazard held for N consecutive cycles stalls N cycles. There is no internal limit; the hazard unit deasserts after the load retires.
- Counters saturate at all-ones; they never wrap.
- Latency: a fetched pair appears on the IF_ID outputs one cycle after capture, absent a stall or flush.
- Reset asserted mid-stall or mid-squash returns immediately to reset values; the first capture happens on the first edge after rst_n rises.

Test Plan:
- Reset then stream: rst_n low 2 cycles, present pairs with if_pc_i=0x00,0x08,0x10 and valid=1.
  - Outputs show each pair one cycle later; pc_write_o=1; id_ex_bubble_o=0; counters 0.
- Single load-use stall: IF_ID holds pc 0x08; assert hazard_i for 1 cycle.
  - IF_ID_pc stays 0x08 for one extra cycle; pc_write_o=0 and id_ex_bubble_o=1 in that cycle; stall_count_o=1; next edge loads 0x10.
- Flush with hazard in the same cycle: hazard_i=1 and flush_i=1.
  - Both lanes = 0x00000000; IF_ID_valid=0; pc_write_o=1; stall_count_o unchanged; flush_count_o=1.
- Multi-cycle squash with FLUSH_CYCLES=3: pulse flush_i while fetch keeps presenting valid pairs.
  - 3 cycles of NOP with valid=0; id_ex_bubble_o=1 for the 2 SQUASH cycles; flush_count_o=3; RUN resumes and captures the next pair.
- Counter saturation with CNT_W=4: hold hazard_i for 20 cycles.
  - stall_count_o reaches 15 and stays at 15; IF_ID outputs frozen throughout.
- Reset mid-squash: assert rst_n low during SQUASH.
  - All outputs return to reset values asynchronously; after release, the first valid pair is captured with no residual squash.
